// File: rtl/if_prefetch_buf_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
// FSM encodings, default reset PC, instruction/PC widths, FIFO entry layout.
package if_prefetch_buf_pkg;

    localparam int IFB_ILEN = 32;
    localparam int IFB_PCW  = 32;

    localparam logic [IFB_PCW-1:0] IFB_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IFB_IDLE  = 2'd0,
        IFB_RUN   = 2'd1,
        IFB_FLUSH = 2'd2
    } ifb_state_e;

    typedef struct packed {
        logic [IFB_PCW-1:0]  pc;
        logic [IFB_ILEN-1:0] inst;
    } ifb_entry_t;

endpackage

// File: rtl/ifb_sync_fifo.sv
// Parameterised synchronous FIFO with flush, occupancy count, full and empty.
// Head data is presented combinationally; push while full is legal with a pop.
module ifb_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch_buf.sv
// Instruction prefetch buffer: credit-limited sequential fetch, in-order
// responses, redirect flush with stale-response drop. Option: IFB_BYPASS_EN.
module if_prefetch_buf
    import if_prefetch_buf_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFB_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        core_inst_valid_o,
    input  logic        core_inst_ready_i,
    output logic [31:0] core_inst_o,
    output logic [31:0] core_pc_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_rsp_valid_i,
    input  logic [31:0] mem_rsp_data_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifb_state_e  state_q;
    ifb_state_e  state_d;
    logic [31:0] fetch_pc_q;
    logic [CW-1:0] drop_cnt_q;
    logic [CW-1:0] drop_cnt_d;
    logic        hold_q;

    logic [CW-1:0] tag_count;
    logic [CW-1:0] inst_count;
    logic [31:0] tag_pc;
    logic        tag_full;
    logic        tag_empty;
    logic        inst_full;
    logic        inst_empty;
    ifb_entry_t  inst_head;
    ifb_entry_t  inst_in;

    logic        credit_ok;
    logic        req_fire;
    logic        rsp_stale;
    logic        rsp_keep;
    logic        byp;
    logic        byp_taken;
    logic        inst_push;
    logic        inst_pop;
    logic        unused_ok;

    // Outstanding requests (stale ones included) equal the tag FIFO occupancy.
    assign credit_ok = ({1'b0, tag_count} + {1'b0, inst_count})
                       < (CW + 1)'(DEPTH);

    assign mem_req_valid_o = hold_q || ((state_q != IFB_IDLE) && credit_ok);
    assign mem_req_addr_o  = fetch_pc_q;
    assign req_fire        = mem_req_valid_o && mem_req_ready_i;

    assign rsp_stale = mem_rsp_valid_i && ((drop_cnt_q != '0) || redirect_i);
    assign rsp_keep  = mem_rsp_valid_i && !rsp_stale;

`ifdef IFB_BYPASS_EN
    assign byp = inst_empty && rsp_keep;
`else
    assign byp = 1'b0;
`endif

    assign byp_taken = byp && core_inst_ready_i;
    assign inst_push = rsp_keep && !byp_taken;
    assign inst_pop  = !inst_empty && core_inst_ready_i;
    assign inst_in   = '{pc: tag_pc, inst: mem_rsp_data_i};

    always_comb begin
        core_inst_valid_o = !inst_empty;
        core_inst_o       = inst_head.inst;
        core_pc_o         = inst_head.pc;
        if (byp) begin
            core_inst_valid_o = 1'b1;
            core_inst_o       = mem_rsp_data_i;
            core_pc_o         = tag_pc;
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (redirect_i) begin
            drop_cnt_d = tag_count + CW'(req_fire) - CW'(mem_rsp_valid_i);
        end else if (mem_rsp_valid_i && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (!fetch_en_i) begin
            state_d = IFB_IDLE;
        end else if (drop_cnt_d != '0) begin
            state_d = IFB_FLUSH;
        end else begin
            state_d = IFB_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IFB_IDLE;
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
            // Keep an unaccepted request stable; a redirect retracts it.
            hold_q     <= mem_req_valid_o && !mem_req_ready_i && !redirect_i;
            if (redirect_i) begin
                fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
            end else if (req_fire) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
        end
    end

    ifb_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (mem_rsp_valid_i),
        .pop_data  (tag_pc),
        .count     (tag_count),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    ifb_sync_fifo #(
        .WIDTH ($bits(ifb_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .push      (inst_push),
        .push_data (inst_in),
        .pop       (inst_pop),
        .pop_data  (inst_head),
        .count     (inst_count),
        .full      (inst_full),
        .empty     (inst_empty)
    );

    assign unused_ok = &{1'b0, tag_full, tag_empty, inst_full,
                         redirect_pc_i[1:0]};

endmodule

// File: tb/tb_if_prefetch_buf.sv
// Directed bench for if_prefetch_buf with a latency-programmable memory
// model and a scoreboard monitor checking every instruction the core takes.
module tb_if_prefetch_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        core_inst_valid_o;
    logic        core_inst_ready_i;
    logic [31:0] core_inst_o;
    logic [31:0] core_pc_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_addr_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;

    if_prefetch_buf #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fetch_en_i        (fetch_en_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .core_inst_valid_o (core_inst_valid_o),
        .core_inst_ready_i (core_inst_ready_i),
        .core_inst_o       (core_inst_o),
        .core_pc_o         (core_pc_o),
        .mem_req_valid_o   (mem_req_valid_o),
        .mem_req_ready_i   (mem_req_ready_i),
        .mem_req_addr_o    (mem_req_addr_o),
        .mem_rsp_valid_i   (mem_rsp_valid_i),
        .mem_rsp_data_i    (mem_rsp_data_i)
    );

    always #5 clk = ~clk;

`ifdef IFB_BYPASS_EN
    localparam int EXP_LAT = 1;
`else
    localparam int EXP_LAT = 2;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];
    int          fire_cyc_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int budget = 0;
    int lat    = 1;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc);
        exp_q.push_back('{pc: pc, inst: word_of(pc)});
    endtask

    task automatic clear_logs();
        req_addr_q.delete();
        req_cyc_q.delete();
        fire_cyc_q.delete();
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        @(negedge clk);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        @(negedge clk);
        redirect_i = 1'b0;
    endtask

    task automatic wait_reqs(input int n, input int maxc);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (req_addr_q.size() < n && k < maxc);
        chk("req_wait", 32'(req_addr_q.size() >= n), 32'd1);
    endtask

    // Memory model: responses in order after a fixed latency.
    always begin
        @(negedge clk);
        #1;
        cyc++;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        if (rst) begin
            pend_q.delete();
            mem_req_ready_i = 1'b0;
        end else begin
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                pend_t p;
                p = pend_q.pop_front();
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = word_of(p.addr);
            end
            mem_req_ready_i = (budget > 0);
            if (mem_req_valid_o && mem_req_ready_i) begin
                budget--;
                pend_q.push_back('{addr: mem_req_addr_o, due: cyc + lat});
                req_addr_q.push_back(mem_req_addr_o);
                req_cyc_q.push_back(cyc);
            end
        end
    end

    // Scoreboard monitor on every core handshake.
    always begin
        @(negedge clk);
        #3;
        if (!rst && core_inst_valid_o && core_inst_ready_i) begin
            fire_cyc_q.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL core_unexpected: got pc %h inst %h want none",
                         core_pc_o, core_inst_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (core_pc_o !== e.pc || core_inst_o !== e.inst) begin
                    bad++;
                    $display("FAIL core_word: got pc %h inst %h want pc %h inst %h",
                             core_pc_o, core_inst_o, e.pc, e.inst);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        fetch_en_i        = 1'b1;
        redirect_i        = 1'b0;
        redirect_pc_i     = '0;
        core_inst_ready_i = 1'b1;
        mem_req_ready_i   = 1'b0;
        mem_rsp_valid_i   = 1'b0;
        mem_rsp_data_i    = '0;

        repeat (2) @(negedge clk);
        chk("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
        chk("rst_req_addr", mem_req_addr_o, 32'h0);
        chk("rst_core_valid", 32'(core_inst_valid_o), 32'd0);
        chk("rst_core_inst", core_inst_o, 32'h0);
        chk("rst_core_pc", core_pc_o, 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'd0);

        // First fetch: 1-cycle memory, ready core.
        budget = 6;
        lat    = 1;
        for (int i = 0; i < 6; i++) exp_push(32'(i * 4));
        clear_logs();
        rst = 1'b0;
        chk("t1_valid_before_edge", 32'(mem_req_valid_o), 32'd0);
        @(negedge clk);
        chk("t1_valid_first", 32'(mem_req_valid_o), 32'd1);
        chk("t1_addr_first", mem_req_addr_o, 32'h0);
        wait_drain(40);
        chk("t1_req0", req_addr_q[0], 32'h0);
        chk("t1_req1", req_addr_q[1], 32'h4);
        chk("t1_req2", req_addr_q[2], 32'h8);
        chk("t1_req_back2back", 32'(req_cyc_q[2] - req_cyc_q[0]), 32'd2);
        chk("t1_core_rate", 32'(fire_cyc_q[5] - fire_cyc_q[0]), 32'd5);
        chk("t1_latency", 32'(fire_cyc_q[0] - req_cyc_q[0]), 32'(EXP_LAT));

        // Back-pressure: core stalled, credits cap requests at DEPTH.
        core_inst_ready_i = 1'b0;
        redirect_to(32'h0);
        clear_logs();
        budget = 100;
        repeat (20) @(negedge clk);
        chk("t2_req_count", 32'(req_addr_q.size()), 32'd4);
        chk("t2_valid_low", 32'(mem_req_valid_o), 32'd0);
        chk("t2_core_valid", 32'(core_inst_valid_o), 32'd1);
        budget = 0;
        for (int i = 0; i < 4; i++) exp_push(32'(i * 4));
        fire_cyc_q.delete();
        core_inst_ready_i = 1'b1;
        wait_drain(40);
        repeat (3) @(negedge clk);
        chk("t2_core_count", 32'(fire_cyc_q.size()), 32'd4);

        // Stale discard: 3-cycle memory, redirect with 2 outstanding.
        lat = 3;
        redirect_to(32'h200);
        clear_logs();
        budget = 2;
        wait_reqs(2, 20);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h103;
        @(negedge clk);
        redirect_i = 1'b0;
        chk("t3_valid", 32'(mem_req_valid_o), 32'd1);
        chk("t3_addr", mem_req_addr_o, 32'h100);
        chk("t3_core_valid", 32'(core_inst_valid_o), 32'd0);
        chk("t3_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
        exp_push(32'h100);
        exp_push(32'h104);
        exp_push(32'h108);
        budget = 3;
        wait_drain(60);

        // Collision: redirect with a request fire and a response together.
        lat = 2;
        repeat (4) @(negedge clk);
        redirect_to(32'h300);
        clear_logs();
        budget = 3;
        wait_reqs(2, 20);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h400;
        @(negedge clk);
        redirect_i = 1'b0;
        chk("t4_fire_in_redirect", 32'(req_addr_q.size()), 32'd3);
        chk("t4_stale_addr", req_addr_q[2], 32'h308);
        chk("t4_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
        chk("t4_addr", mem_req_addr_o, 32'h400);
        chk("t4_core_valid", 32'(core_inst_valid_o), 32'd0);
        exp_push(32'h400);
        exp_push(32'h404);
        budget = 2;
        wait_drain(60);

        // PC wrap.
        lat = 1;
        repeat (4) @(negedge clk);
        redirect_to(32'hffff_fffc);
        chk("t5_addr", mem_req_addr_o, 32'hffff_fffc);
        clear_logs();
        exp_push(32'hffff_fffc);
        exp_push(32'h0000_0000);
        budget = 2;
        wait_drain(40);
        chk("t5_wrap_req", req_addr_q[1], 32'h0);
        chk("t5_next_addr", mem_req_addr_o, 32'h4);

        // Fetch disable: redirect retracts the held request, FSM idles.
        fetch_en_i = 1'b0;
        redirect_to(32'h500);
        chk("t6_valid_idle", 32'(mem_req_valid_o), 32'd0);
        chk("t6_state_idle", 32'(dut.state_q), 32'd0);
        chk("t6_addr", mem_req_addr_o, 32'h500);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
